// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_BYTES : byte stride between consecutive instruction words
//   DISCARD_W   : width of the stale-response counter; a redirect adds at most
//                 FIFO_DEPTH stale responses, so this covers many back-to-back
//                 redirects against a slow memory.
//   ifu_state_e : IFU_RUN (normal), IFU_DRAIN (dropping stale responses),
//                 IFU_HALT (misaligned redirect trap, only reachable with
//                 IFU_MISALIGN_TRAP_EN defined)
package instr_fetch_unit_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DISCARD_W   = 8;

  typedef enum logic [1:0] {
    IFU_RUN   = 2'd0,
    IFU_DRAIN = 2'd1,
    IFU_HALT  = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and decode.
//   redirect_valid/redirect_pc         : branch/jump target from execute
//   imem_req_valid/addr/ready          : fetch request channel to memory
//   imem_rsp_valid/data                : in-order responses from memory
//   instr_valid/instr/instr_pc/ready   : instruction handshake to decode
//   fetch_misaligned                   : present only with IFU_MISALIGN_TRAP_EN
// Modport master is the fetch unit side, slave the environment side.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
`ifdef IFU_MISALIGN_TRAP_EN
  logic            fetch_misaligned;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
           fetch_misaligned
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
           fetch_misaligned
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
  );
`endif

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used as the instruction buffer.
//   clk, rst   : clock, synchronous active-high reset (control state only)
//   push/din   : write an entry (ignored when full unless popping same cycle)
//   pop/dout   : dout shows the head; pop removes it (ignored when empty)
//   flush      : empties the FIFO, takes priority over push/pop
//   empty/count: occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so push is legal when full.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: flow-controlled instruction fetcher.
// Owns the PC, issues word-aligned requests to a variable-latency memory,
// buffers in-order responses with their PCs, and hands {instr, instr_pc} to
// decode over valid/ready. A redirect flushes buffered and in-flight fetches.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.master (redirect, imem req/rsp, decode)
// Optional feature macro: IFU_MISALIGN_TRAP_EN -- a misaligned redirect halts
// fetching and raises bus.fetch_misaligned instead of clearing the low bits.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e           state;
  ifu_state_e           state_nxt;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      rsp_pc;
  logic [XLEN-1:0]      redirect_tgt;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       inflight;
  logic [DISCARD_W-1:0] discard;
  logic [DISCARD_W-1:0] discard_nxt;
  logic [2*XLEN-1:0]    fifo_dout;
  logic                 fifo_empty;
  logic                 misaligned_redirect;
  logic                 issue_en;
  logic                 req_fire;
  logic                 rsp_drop;
  logic                 rsp_keep;
  logic                 push;
  logic                 pop;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned_redirect = (bus.redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = misaligned_redirect ? bus.redirect_pc
                                            : {bus.redirect_pc[XLEN-1:2], 2'b00};
`else
  assign misaligned_redirect = 1'b0;
  assign redirect_tgt        = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

  // Credit: every request still in memory or buffered owns a FIFO slot, so
  // responses can always be accepted without back-pressure.
  assign inflight           = (CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count);
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && issue_en &&
                              (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses are in order, so the oldest discard-count responses are stale.
  assign rsp_drop = bus.imem_rsp_valid && (discard != '0);
  assign rsp_keep = bus.imem_rsp_valid && (discard == '0);
  assign push     = rsp_keep && !bus.redirect_valid;

  assign bus.instr_valid = !rst && !fifo_empty && !bus.redirect_valid;
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign bus.instr       = fifo_dout[2*XLEN-1:XLEN];
  assign bus.instr_pc    = fifo_dout[XLEN-1:0];

  // On redirect everything still in memory becomes stale; a response arriving
  // this cycle is already accounted for, whichever counter it came from.
  always_comb begin
    discard_nxt = discard;
    if (bus.redirect_valid)
      discard_nxt = discard + DISCARD_W'(outstanding) - DISCARD_W'(bus.imem_rsp_valid);
    else if (rsp_drop)
      discard_nxt = discard - DISCARD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      discard <= discard_nxt;
      if (bus.redirect_valid) begin
        pc          <= redirect_tgt;
        rsp_pc      <= redirect_tgt;
        outstanding <= '0;
      end else begin
        if (req_fire) pc <= pc + XLEN'(INSTR_BYTES);
        // Requests after a redirect are sequential, so the PC of the next kept
        // response is simply the previous one plus a word.
        if (push) rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
        outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_keep);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ({bus.imem_rsp_data, rsp_pc}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IFU_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      if (misaligned_redirect)      state_nxt = IFU_HALT;
      else if (discard_nxt != '0)   state_nxt = IFU_DRAIN;
      else                          state_nxt = IFU_RUN;
    end else if (state != IFU_HALT) begin
      state_nxt = (discard_nxt != '0) ? IFU_DRAIN : IFU_RUN;
    end
  end

  always_comb begin
    issue_en = (state != IFU_HALT);
`ifdef IFU_MISALIGN_TRAP_EN
    bus.fetch_misaligned = (state == IFU_HALT);
`endif
  end

endmodule
